// File: rtl/rom_search_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rom_search_pkg : opcodes, FSM states and default widths for rom_search_arbiter
// Revision: 1.0
// ============================================================================
package rom_search_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] OP_MAX   = 2'b00;
  localparam logic [1:0] OP_MIN   = 2'b01;
  localparam logic [1:0] OP_MATCH = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_search_arbiter_if.sv
`default_nettype none
// ============================================================================
// rom_search_arbiter_if : requester-side job bus of the ROM search arbiter
// Revision: 1.0
// ============================================================================
interface rom_search_arbiter_if #(
  parameter int ADDR_W = rom_search_pkg::DEF_ADDR_W,
  parameter int DATA_W = rom_search_pkg::DEF_DATA_W
);
  logic [1:0]        req;
  logic [1:0]        op0;
  logic [1:0]        op1;
  logic [DATA_W-1:0] key0;
  logic [DATA_W-1:0] key1;
  logic [1:0]        grant;
  logic              busy;
  logic [1:0]        done;
  logic [ADDR_W-1:0] result_addr;
  logic [DATA_W-1:0] result_data;
  logic              found;
  logic              err;

  modport master (
    output req, op0, op1, key0, key1,
    input  grant, busy, done, result_addr, result_data, found, err
  );

  modport slave (
    input  req, op0, op1, key0, key1,
    output grant, busy, done, result_addr, result_data, found, err
  );
endinterface
`default_nettype wire

// File: rtl/rom_search_arbiter_rr.sv
`default_nettype none
// ============================================================================
// rr_arbiter_2 : combinational two-way round-robin pick, one-hot grant
// Revision: 1.0
// ============================================================================
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the requester not served last wins
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rom_search_arbiter.sv
`default_nettype none
// ============================================================================
// rom_search_arbiter : shares one sync-read ROM between two requesters and runs
// MAX / MIN / MATCH full-table searches. Optional MIN: `ROM_SEARCH_MIN_EN.
// Revision: 1.0
// ============================================================================
module rom_search_arbiter
  import rom_search_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_a_p,
  rom_search_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  function automatic logic op_legal(input logic [1:0] op);
`ifdef ROM_SEARCH_MIN_EN
    return (op == OP_MAX) || (op == OP_MIN) || (op == OP_MATCH);
`else
    return (op == OP_MAX) || (op == OP_MATCH);
`endif
  endfunction

  state_t            state_q, state_d;
  logic              id_q, id_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] best_q, best_d;
  logic [ADDR_W-1:0] best_addr_q, best_addr_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              found_q, found_d;
  logic              err_q, err_d;

  logic [1:0]        pick;
  logic              sel_id;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_key;
  logic              better, hit, upd;
  logic [DATA_W-1:0] best_nxt;
  logic [ADDR_W-1:0] best_addr_nxt;
  logic [1:0]        id_onehot;

  rr_arbiter_2 u_arb (
    .req   (bus.req),
    .last  (last_q),
    .grant (pick)
  );

  assign sel_id  = pick[1];
  assign sel_op  = sel_id ? bus.op1  : bus.op0;
  assign sel_key = sel_id ? bus.key1 : bus.key0;

  // Compare stage: rom_data belongs to rd_addr_q, issued one cycle earlier
  always_comb begin
`ifdef ROM_SEARCH_MIN_EN
    better = (op_q == OP_MIN) ? (rom_data < best_q) : (rom_data > best_q);
`else
    better = (rom_data > best_q);
`endif
    hit           = rd_valid_q && (op_q == OP_MATCH) && (rom_data == key_q);
    upd           = rd_valid_q && (op_q != OP_MATCH) && ((rd_addr_q == '0) || better);
    best_nxt      = upd ? rom_data  : best_q;
    best_addr_nxt = upd ? rd_addr_q : best_addr_q;
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    op_d        = op_q;
    key_d       = key_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    rd_valid_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    best_d      = best_nxt;
    best_addr_d = best_addr_nxt;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;
    found_d     = found_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          id_d  = sel_id;
          op_d  = sel_op;
          key_d = sel_key;
          if (op_legal(sel_op)) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            found_d = 1'b0;
          end
        end
      end
      ST_SCAN: begin
        rd_valid_d = 1'b1;
        rd_addr_d  = cnt_q;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        err_d   = 1'b0;
        if (op_q == OP_MATCH) begin
          found_d    = 1'b0;
          res_addr_d = '0;
          res_data_d = '0;
        end else begin
          found_d    = 1'b1;
          res_addr_d = best_addr_nxt;
          res_data_d = best_nxt;
        end
      end
      ST_DONE: begin
        last_d  = id_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A MATCH hit aborts the scan; the read in flight is dropped
    if (hit) begin
      state_d    = ST_DONE;
      cnt_d      = cnt_q;
      rd_valid_d = 1'b0;
      res_addr_d = rd_addr_q;
      res_data_d = rom_data;
      found_d    = 1'b1;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      state_q     <= ST_IDLE;
      id_q        <= 1'b0;
      op_q        <= 2'b00;
      key_q       <= '0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      best_q      <= '0;
      best_addr_q <= '0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      op_q        <= op_d;
      key_q       <= key_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      best_q      <= best_d;
      best_addr_q <= best_addr_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
      found_q     <= found_d;
      err_q       <= err_d;
    end
  end

  assign id_onehot       = id_q ? 2'b10 : 2'b01;
  assign rom_addr        = cnt_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.grant       = (state_q != ST_IDLE) ? id_onehot : 2'b00;
  assign bus.done        = (state_q == ST_DONE) ? id_onehot : 2'b00;
  assign bus.result_addr = res_addr_q;
  assign bus.result_data = res_data_q;
  assign bus.found       = found_q;
  assign bus.err         = err_q;

endmodule
`default_nettype wire
